// File: rtl/pcs_pkg.sv
// Shared 64b66b PCS definitions: sync header codes, block-lock states and
// the header validity check used by the receive path.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    WAIT,
    LOCKED
  } block_lock_state_t;

  // Only the two transition patterns are legal; 00/11 mean we are misaligned.
  function automatic logic is_valid_sync(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 64b66b block-lock FSM: slips the upstream gearbox until LOCK_COUNT good sync
// headers arrive in a row, then monitors bad headers per window to drop lock.
module rx_block_lock
  import pcs_pkg::*;
#(
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_THRESH = 16,
  parameter int SLIP_WAIT     = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_header,
  input  logic       i_header_valid,
  output logic       o_slip,
  output logic       o_block_lock,
  output logic       o_lock_lost
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_THRESH - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(SLIP_WAIT - 1);

  block_lock_state_t state_reg, state_next;
  logic [CW-1:0] sh_cnt_reg, sh_cnt_next;
  logic [CW-1:0] inv_cnt_reg, inv_cnt_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic slip_reg, slip_next;
  logic lock_reg, lock_next;
  logic lost_reg, lost_next;
  logic hdr_ok;

  assign hdr_ok = is_valid_sync(i_header);

  always_comb begin
    state_next    = state_reg;
    sh_cnt_next   = sh_cnt_reg;
    inv_cnt_next  = inv_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    lock_next     = lock_reg;
    slip_next     = 1'b0;
    lost_next     = 1'b0;

    case (state_reg)
      HUNT: begin
        if (i_header_valid) begin
          if (!hdr_ok) begin
            state_next  = SLIP;
            sh_cnt_next = '0;
          end else if (sh_cnt_reg == LOCK_LAST) begin
            state_next   = LOCKED;
            lock_next    = 1'b1;
            sh_cnt_next  = '0;
            inv_cnt_next = '0;
          end else begin
            sh_cnt_next = sh_cnt_reg + CW'(1);
          end
        end
      end

      // Single-cycle state regardless of strobes, so slips can never be adjacent.
      SLIP: begin
        slip_next     = 1'b1;
        state_next    = WAIT;
        wait_cnt_next = '0;
      end

      WAIT: begin
        if (i_header_valid) begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next    = HUNT;
            sh_cnt_next   = '0;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt_reg + WW'(1);
          end
        end
      end

      LOCKED: begin
        if (i_header_valid) begin
          // Unlock is tested first so it wins on the last strobe of a window.
          if (!hdr_ok && (inv_cnt_reg == UNLOCK_LAST)) begin
            state_next   = SLIP;
            lock_next    = 1'b0;
            lost_next    = 1'b1;
            sh_cnt_next  = '0;
            inv_cnt_next = '0;
          end else if (sh_cnt_reg == LOCK_LAST) begin
            sh_cnt_next  = '0;
            inv_cnt_next = '0;
          end else begin
            sh_cnt_next = sh_cnt_reg + CW'(1);
            if (!hdr_ok) begin
              inv_cnt_next = inv_cnt_reg + CW'(1);
            end
          end
        end
      end

      default: begin
        state_next   = HUNT;
        lock_next    = 1'b0;
        sh_cnt_next  = '0;
        inv_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= HUNT;
      sh_cnt_reg   <= '0;
      inv_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      slip_reg     <= 1'b0;
      lock_reg     <= 1'b0;
      lost_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_cnt_reg   <= sh_cnt_next;
      inv_cnt_reg  <= inv_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      slip_reg     <= slip_next;
      lock_reg     <= lock_next;
      lost_reg     <= lost_next;
    end
  end

  assign o_slip       = slip_reg;
  assign o_block_lock = lock_reg;
  assign o_lock_lost  = lost_reg;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: stimulus queues the expected output events
// (lock up/down, lock-lost pulse, slip pulse) with their cycle; a monitor checks them.
module tb_rx_block_lock;

  localparam int EV_UP   = 0;
  localparam int EV_DN   = 1;
  localparam int EV_LOST = 2;
  localparam int EV_SLIP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] header = 2'b00;
  logic       header_valid = 1'b0;
  logic       slip, block_lock, lock_lost;

  rx_block_lock #(
    .LOCK_COUNT   (64),
    .UNLOCK_THRESH(16),
    .SLIP_WAIT    (2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_header      (header),
    .i_header_valid(header_valid),
    .o_slip        (slip),
    .o_block_lock  (block_lock),
    .o_lock_lost   (lock_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  last_c = 0;
  bit  done = 1'b0;

  function automatic string ev_name(input int k);
    case (k)
      EV_UP:   return "lock_up";
      EV_DN:   return "lock_down";
      EV_LOST: return "lock_lost";
      default: return "slip";
    endcase
  endfunction

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input logic [1:0] h);
    @(negedge clk);
    header       = h;
    header_valid = 1'b1;
    last_c       = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      header_valid = 1'b0;
      header       = 2'b00;
    end
  endtask

  task automatic burst(input int n, input logic [1:0] h);
    for (int i = 0; i < n; i++) strobe(h);
  endtask

  // Sends strobes 0..stop of a 64-header window; positions lo..hi carry bad headers.
  task automatic window(input int lo, input int hi, input int stop);
    for (int p = 0; p <= stop; p++) begin
      if (p >= lo && p <= hi) strobe((p % 2) != 0 ? 2'b11 : 2'b00);
      else strobe((p % 2) != 0 ? 2'b10 : 2'b01);
    end
  endtask

  // Monitor: all comparisons and the summary live here.
  logic prev_lock = 1'b0;

  task automatic check_ev(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at cycle %0d, required no event", ev_name(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                 ev_name(k), cyc, ev_name(e.kind), e.at);
      end else begin
        $display("ok   event %s at cycle %0d", ev_name(k), cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset && cyc > 0) begin
      checks++;
      if ({slip, block_lock, lock_lost} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d got slip/lock/lost=%b, required 000",
                 cyc, {slip, block_lock, lock_lost});
      end else begin
        $display("ok   reset outputs zero at cycle %0d", cyc);
      end
    end
    if (block_lock !== prev_lock) check_ev(block_lock === 1'b1 ? EV_UP : EV_DN);
    if (lock_lost === 1'b1) check_ev(EV_LOST);
    if (slip === 1'b1) check_ev(EV_SLIP);
    prev_lock = block_lock;
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events: got %0d outstanding, required 0 (next %s at %0d)",
                 exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].at);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with random header traffic.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      header       = 2'($urandom_range(0, 3));
      header_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset        = 1'b0;
    header_valid = 1'b0;

    // Hunt slip: 10 good, then a bad header; slip appears two cycles later.
    burst(10, 2'b01);
    strobe(2'b11);
    push(EV_SLIP, last_c + 2);
    idle(1);
    burst(2, 2'b00);
    // Clean lock with a gap of non-strobe cycles mid-count; 63 strobes must not lock.
    burst(30, 2'b01);
    idle(3);
    burst(33, 2'b10);
    strobe(2'b10);
    push(EV_UP, last_c + 1);

    // Window 1: 15 bad holds lock. Window 2: 16th bad drops it.
    window(0, 14, 63);
    window(10, 25, 25);
    push(EV_DN, last_c + 1);
    push(EV_LOST, last_c + 1);
    push(EV_SLIP, last_c + 2);
    strobe(2'b11);
    burst(2, 2'b11);
    burst(64, 2'b01);
    push(EV_UP, last_c + 1);

    // 15 bad ending on the window's last strobe, then 15 more at the next window start.
    window(49, 63, 63);
    window(0, 14, 63);
    // Invalid last strobe reaching the threshold: unlock beats window end.
    window(48, 63, 63);
    push(EV_DN, last_c + 1);
    push(EV_LOST, last_c + 1);
    push(EV_SLIP, last_c + 2);
    idle(1);
    burst(2, 2'b01);

    // Mid-hunt reset must clear the good-header count.
    burst(40, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    header_valid = 1'b1;
    header = 2'b01;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    header_valid = 1'b0;
    burst(63, 2'b01);
    idle(2);
    strobe(2'b01);
    push(EV_UP, last_c + 1);

    idle(5);
    done = 1'b1;
  end

endmodule
